// File: rtl/core_defs.sv
// Shared definitions for the RV32I pipeline control slice:
// FSM state encodings and common word constants.
package core_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1
  } state_t;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int          FLUSH_CNT_W  = 4;

endpackage

// File: rtl/hold_timer.sv
// Saturating bus-hold cycle counter with a single pulse
// on the cycle the count first reaches HOLD_TIMEOUT.
module hold_timer #(
  parameter int HOLD_TIMEOUT = 256,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_hold,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] PRE_LIM  = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic             ENABLED  = (HOLD_TIMEOUT != 0);

  logic [CNT_W-1:0] cnt;

  // Count consecutive hold cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (!bus_hold) begin
      cnt <= {CNT_W{1'b0}};
    end else if (ENABLED && (cnt != LIMIT)) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  // The pulse is the cycle whose edge moves the count onto the limit.
  always_comb begin
    timeout = 1'b0;
    if (ENABLED && !rst && bus_hold && (cnt == PRE_LIM)) begin
      timeout = 1'b1;
    end else begin
      timeout = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline controller: arbitrates jump, stall and interrupt requests into a
// PC redirect plus IF/ID and ID/EX bubble controls, with a post-redirect flush window.
module pipe_hold_ctrl
  import core_defs::*;
#(
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int HOLD_TIMEOUT = 256,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_hold_req_i,
  input  logic          bus_hold_req_i,
  input  logic          irq_req_i,
  input  logic [AW-1:0] irq_addr_i,
  output logic          pc_jump_o,
  output logic [AW-1:0] pc_jump_addr_o,
  output logic          pc_hold_o,
  output logic          if_id_bubble_o,
  output logic          id_ex_bubble_o,
  output logic          irq_ack_o,
  output logic          bus_timeout_o,
  output logic [1:0]    state_o
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam state_t                 REDIR_STATE = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;

  state_t                 state;
  state_t                 next_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] next_flush_cnt;
  logic                   stall;
  logic                   timer_pulse;

  hold_timer #(
    .HOLD_TIMEOUT (HOLD_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .bus_hold (bus_hold_req_i),
    .timeout  (timer_pulse)
  );

  assign stall         = ex_hold_req_i | bus_hold_req_i;
  assign bus_timeout_o = timer_pulse;
  assign state_o       = state;

  // FSM state and flush window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= {FLUSH_CNT_W{1'b0}};
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
    end
  end

  // Request arbitration (jump > stall > irq) and output decode.
  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    pc_jump_o      = 1'b0;
    pc_jump_addr_o = AW'(ZERO_WORD);
    pc_hold_o      = 1'b0;
    if_id_bubble_o = 1'b0;
    id_ex_bubble_o = 1'b0;
    irq_ack_o      = 1'b0;

    if (rst) begin
      // Pipe registers are held at NOP while in reset.
      if_id_bubble_o = 1'b1;
      id_ex_bubble_o = 1'b1;
      next_state     = IDLE;
      next_flush_cnt = {FLUSH_CNT_W{1'b0}};
    end else if (jump_req_i) begin
      pc_jump_o      = 1'b1;
      pc_jump_addr_o = jump_addr_i;
      if_id_bubble_o = 1'b1;
      id_ex_bubble_o = 1'b1;
      next_state     = REDIR_STATE;
      next_flush_cnt = FLUSH_LOAD;
    end else if (stall) begin
      pc_hold_o      = 1'b1;
      if_id_bubble_o = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (irq_req_i) begin
            pc_jump_o      = 1'b1;
            pc_jump_addr_o = irq_addr_i;
            if_id_bubble_o = 1'b1;
            id_ex_bubble_o = 1'b1;
            irq_ack_o      = 1'b1;
            next_state     = REDIR_STATE;
            next_flush_cnt = FLUSH_LOAD;
          end else begin
            next_state = IDLE;
          end
        end
        FLUSH: begin
          if_id_bubble_o = 1'b1;
          if (flush_cnt <= {{(FLUSH_CNT_W-1){1'b0}}, 1'b1}) begin
            next_state     = IDLE;
            next_flush_cnt = {FLUSH_CNT_W{1'b0}};
          end else begin
            next_flush_cnt = flush_cnt - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          // Unreachable encodings recover to IDLE with the pipe flushed.
          if_id_bubble_o = 1'b1;
          id_ex_bubble_o = 1'b1;
          next_state     = IDLE;
          next_flush_cnt = {FLUSH_CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl (FLUSH_CYCLES=2, HOLD_TIMEOUT=4): each
// directed step queues its hand-computed outputs; a monitor pops and compares.
module tb_pipe_hold_ctrl;

  typedef struct packed {
    logic        pj;
    logic [31:0] addr;
    logic        ph;
    logic        ifb;
    logic        idb;
    logic        ack;
    logic        to;
    logic [1:0]  st;
  } vec_t;

  typedef struct packed {
    int   id;
    vec_t v;
  } exp_t;

  localparam logic [31:0] JA  = 32'h0000_0100;
  localparam logic [31:0] JB  = 32'h0000_0300;
  localparam logic [31:0] IA  = 32'h0000_0200;
  localparam logic [1:0]  SI  = 2'd0;
  localparam logic [1:0]  SF  = 2'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        ex_hold_req_i = 1'b0;
  logic        bus_hold_req_i = 1'b0;
  logic        irq_req_i = 1'b0;
  logic [31:0] irq_addr_i = 32'h0;
  logic        pc_jump_o;
  logic [31:0] pc_jump_addr_o;
  logic        pc_hold_o;
  logic        if_id_bubble_o;
  logic        id_ex_bubble_o;
  logic        irq_ack_o;
  logic        bus_timeout_o;
  logic [1:0]  state_o;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  pipe_hold_ctrl #(
    .AW           (32),
    .FLUSH_CYCLES (2),
    .HOLD_TIMEOUT (4),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .ex_hold_req_i  (ex_hold_req_i),
    .bus_hold_req_i (bus_hold_req_i),
    .irq_req_i      (irq_req_i),
    .irq_addr_i     (irq_addr_i),
    .pc_jump_o      (pc_jump_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .pc_hold_o      (pc_hold_o),
    .if_id_bubble_o (if_id_bubble_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .irq_ack_o      (irq_ack_o),
    .bus_timeout_o  (bus_timeout_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic pj, input logic [31:0] addr, input logic ph,
                              input logic ifb, input logic idb, input logic ack,
                              input logic to, input logic [1:0] st);
    vec_t v;
    v.pj = pj; v.addr = addr; v.ph = ph; v.ifb = ifb; v.idb = idb;
    v.ack = ack; v.to = to; v.st = st;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the expectation.
  task automatic step(input logic r, input logic j, input logic [31:0] ja,
                      input logic eh, input logic bh, input logic irq,
                      input vec_t e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; jump_req_i = j; jump_addr_i = ja;
    ex_hold_req_i = eh; bus_hold_req_i = bh; irq_req_i = irq; irq_addr_i = IA;
    x.id = step_id;
    x.v  = e;
    q.push_back(x);
    step_id++;
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      vec_t a;
      x = q.pop_front();
      a = mk(pc_jump_o, pc_jump_addr_o, pc_hold_o, if_id_bubble_o, id_ex_bubble_o,
             irq_ack_o, bus_timeout_o, state_o);
      checks++;
      if (a !== x.v) begin
        errors++;
        $display("FAIL step%0d: got pj=%b addr=%h ph=%b ifb=%b idb=%b ack=%b to=%b st=%0d, expected pj=%b addr=%h ph=%b ifb=%b idb=%b ack=%b to=%b st=%0d",
                 x.id, a.pj, a.addr, a.ph, a.ifb, a.idb, a.ack, a.to, a.st,
                 x.v.pj, x.v.addr, x.v.ph, x.v.ifb, x.v.idb, x.v.ack, x.v.to, x.v.st);
      end
    end
  end

  initial begin
    // Reset for two cycles, then idle
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Jump with a two-cycle flush window
    step(1'b0, 1'b1, JA, 1'b0, 1'b0, 1'b0, mk(1'b1, JA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // EX stall inside the flush window freezes the remaining flush cycle
    step(1'b0, 1'b1, JA, 1'b0, 1'b0, 1'b0, mk(1'b1, JA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Jump during FLUSH reloads the window
    step(1'b0, 1'b1, JA, 1'b0, 1'b0, 1'b0, mk(1'b1, JA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b1, JB, 1'b0, 1'b0, 1'b0, mk(1'b1, JB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SF));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Irq loses to a jump, is not taken in FLUSH, then taken once in IDLE
    step(1'b0, 1'b1, JA, 1'b0, 1'b0, 1'b1, mk(1'b1, JA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, mk(1'b1, IA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SI));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Irq blocked by a 5-cycle bus hold (timeout fires in hold cycle 4)
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1,
           mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, mk(1'b1, IA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SI));
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Bus timeout: 10-cycle episode, release, 4-cycle episode
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
           mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0,
           mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Reset mid-FLUSH returns to IDLE
    step(1'b0, 1'b1, JA, 1'b0, 1'b0, 1'b0, mk(1'b1, JA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SF));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SI));

    // Reset mid-stall with pending irq; hold count restarts, irq taken after reset
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, mk(1'b1, IA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, SI));
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, SF));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && q.size() != 0; i++)
      @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Central pipeline controller for the 3-stage RV32I core (IF/ID, ID/EX registers built from gen_pipe_dff). It resolves jump, multicycle-hold, bus-wait and interrupt requests into one PC redirect plus per-stage bubble and hold controls. The bubble outputs drive the hold_en inputs of the pipe DFFs, which force those registers to their default NOP value. A small FSM enforces post-redirect flush windows and takes interrupts only at instruction boundaries. A counter flags stuck bus waits.

Parameters:
AW, 32, PC/jump address width
FLUSH_CYCLES, 1, extra cycles of IF/ID bubble after any redirect (0..15; 0 = no FLUSH state)
HOLD_TIMEOUT, 256, consecutive bus_hold cycles before bus_timeout_o pulses (0 = disabled)
CNT_W, 16, width of the bus-hold counter; must satisfy HOLD_TIMEOUT < 2**CNT_W

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous reset, active-high
jump_req_i  in  1  EX-stage taken branch/jump
jump_addr_i  in  AW  jump target
ex_hold_req_i  in  1  multicycle EX op busy (div/mul)
bus_hold_req_i  in  1  memory bus not ready
irq_req_i  in  1  level interrupt request
irq_addr_i  in  AW  interrupt vector
pc_jump_o  out  1  PC load strobe
pc_jump_addr_o  out  AW  PC load value
pc_hold_o  out  1  freeze PC
if_id_bubble_o  out  1  to IF/ID dff hold_en
id_ex_bubble_o  out  1  to ID/EX dff hold_en
irq_ack_o  out  1  1-cycle interrupt-taken pulse
bus_timeout_o  out  1  1-cycle stuck-bus pulse
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset: rst=1 at the clock edge sets state=IDLE, flush_cnt=0, hold_cnt=0. While rst=1, outputs are: bubbles=1, pc_hold=0, pc_jump=0, pc_jump_addr=0, irq_ack=0, bus_timeout=0.
- Control outputs are combinational from state and inputs (zero latency). Only state and counters are registered.
- States: IDLE=0, FLUSH=1.
- Priority in any state: jump > stall (ex_hold | bus_hold) > irq.
- Jump (jump_req_i=1):
  - Outputs: pc_jump=1, addr=jump_addr_i, both bubbles=1, pc_hold=0.
  - Next state: FLUSH with flush_cnt=FLUSH_CYCLES if FLUSH_CYCLES>0, else IDLE.
  - A jump while in FLUSH is honoured and reloads flush_cnt.
- Stall (no jump, ex_hold|bus_hold):
  - Outputs: pc_hold=1, both bubbles=1, pc_jump=0. State is unchanged and flush_cnt is frozen.
  - Contract: the EX unit re-issues a jump to the next PC when its multicycle op completes. This controller does not replay instructions.
- Interrupt:
  - Accepted only in IDLE with no jump and no stall in the same cycle.
  - Outputs: pc_jump=1, addr=irq_addr_i, both bubbles=1, irq_ack=1 for exactly that cycle.
  - Next state: FLUSH or IDLE, following the same rule as a jump.
  - irq_req_i still high in the following cycles is not re-taken while in FLUSH. The source must drop it after irq_ack.
  - An irq blocked by a jump or stall stays pending (level). It is taken on the first eligible IDLE cycle.
- FLUSH with no jump or stall:
  - Outputs: if_id_bubble=1, id_ex_bubble=0, pc_hold=0.
  - flush_cnt decrements; on reaching 1, next state is IDLE.
- IDLE with no requests: all outputs 0.
- Bus timeout:
  - hold_cnt increments each cycle bus_hold_req_i=1 and saturates at HOLD_TIMEOUT. It clears to 0 in any cycle bus_hold_req_i=0.
  - bus_timeout_o=1 only in the cycle hold_cnt transitions to HOLD_TIMEOUT: one pulse per continuous hold episode.
  - Stalling continues regardless of the pulse.
  - HOLD_TIMEOUT=0: bus_timeout_o is held at 0.
- Reset mid-FLUSH or mid-stall: the next cycle is IDLE with counters at 0, and any pending irq is re-evaluated.

Decomposition:
- Shared package (core_defs): state encodings IDLE/FLUSH, ZERO_WORD, and the reset vector constant.
- Sub-module hold_timer: the saturating bus-hold counter with its one-pulse detect (parameters HOLD_TIMEOUT, CNT_W).
- The FSM and output decode stay in pipe_hold_ctrl.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all inputs 0 -> during reset bubbles=1; after reset all outputs 0 and state_o=0.
- Jump, FLUSH_CYCLES=2, jump_addr_i=0x100 for 1 cycle -> cycle0: pc_jump=1, addr=0x100, both bubbles=1. Cycles 1-2: if_id_bubble=1 only. Cycle3: all outputs 0.
- Stall during FLUSH: jump, then ex_hold_req_i=1 for 3 cycles at flush cycle 1 -> pc_hold=1 and both bubbles for 3 cycles. The remaining flush cycle completes afterwards.
- Interrupt arbitration: irq_req_i=1 and jump_req_i=1 in the same cycle -> jump taken, irq_ack=0. After FLUSH, pc_jump=1 with addr=irq_addr_i and irq_ack=1 for exactly 1 cycle.
- Irq blocked by stall: irq_req_i=1 with bus_hold_req_i=1 for 5 cycles -> irq_ack=0 throughout. It is taken on the first cycle after bus_hold drops.
- Bus timeout, HOLD_TIMEOUT=4: bus_hold=1 for 10 cycles, release, then bus_hold=1 for 4 cycles -> one pulse in the 4th cycle of each episode, none in between.
